// File: rtl/hdmi_sched_pkg.sv
// Shared types and constants for the HDMI data-island scheduler.
// Build option: HDMI_SCHED_INFOFRAME_RR_EN (consumed by hdmi_sched_arbiter).
package hdmi_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_LGUARD   = 3'd3,
        ST_PACKET   = 3'd4,
        ST_TGUARD   = 3'd5,
        ST_DONE     = 3'd6
    } sched_state_t;

    localparam logic [1:0] SRC_ACR = 2'd0;
    localparam logic [1:0] SRC_AUD = 2'd1;
    localparam logic [1:0] SRC_AVI = 2'd2;
    localparam logic [1:0] SRC_AIF = 2'd3;

    localparam logic [5:0] PREAMBLE_LEN = 6'd8;
    localparam logic [5:0] GUARD_LEN    = 6'd2;
    localparam logic [5:0] PACKET_LEN   = 6'd32;

    function automatic logic [3:0] src_onehot(input logic [1:0] idx);
        src_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/hdmi_sched_arbiter.sv
// Packet source arbiter: ACR > audio sample > infoframes.
// With HDMI_SCHED_INFOFRAME_RR_EN defined, AVI and audio infoframe alternate at the lowest level.
module hdmi_sched_arbiter
    import hdmi_sched_pkg::*;
(
    input  logic       i_pixclk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    input  logic       i_take,
    output logic       o_valid,
    output logic [1:0] o_idx
);

`ifdef HDMI_SCHED_INFOFRAME_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    logic       r_rr_ptr;
    logic [1:0] w_idx;

    // Priority pick; r_rr_ptr=1 favours the audio infoframe when both infoframes wait
    always_comb begin
        w_idx = SRC_ACR;
        if (i_req[SRC_ACR]) begin
            w_idx = SRC_ACR;
        end else if (i_req[SRC_AUD]) begin
            w_idx = SRC_AUD;
        end else if (i_req[SRC_AIF] && (!i_req[SRC_AVI] || r_rr_ptr)) begin
            w_idx = SRC_AIF;
        end else if (i_req[SRC_AVI]) begin
            w_idx = SRC_AVI;
        end else begin
            w_idx = SRC_ACR;
        end
    end

    // Pointer toggles after every accepted infoframe grant
    always_ff @(posedge i_pixclk) begin
        if (!i_rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (RR_EN && i_take && w_idx[1]) begin
            r_rr_ptr <= ~r_rr_ptr;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    assign o_valid = |i_req;
    assign o_idx   = w_idx;

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Data-island scheduler: times preamble/guard/packet periods after each blank rising edge.
// Build option: HDMI_SCHED_INFOFRAME_RR_EN enables infoframe round-robin in the arbiter.
module hdmi_island_scheduler
    import hdmi_sched_pkg::*;
#(
    parameter int START_DLY = 12,
    parameter int MAX_PKTS  = 2
) (
    input  logic       i_pixclk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_blank,
    input  logic [3:0] i_req,
    output logic [3:0] o_grant,
    output logic [1:0] o_pkt_sel,
    output logic       o_preamble,
    output logic       o_guard,
    output logic       o_data,
    output logic       o_first,
    output logic       o_abort
);

    // The detect cycle itself is control period, so DELAY starts counting at 1
    localparam logic [5:0] DLY_LAST   = 6'(START_DLY - 1);
    localparam logic [5:0] PRE_LAST   = PREAMBLE_LEN - 6'd1;
    localparam logic [5:0] GUARD_LAST = GUARD_LEN - 6'd1;
    localparam logic [5:0] PKT_LAST   = PACKET_LEN - 6'd1;
    localparam logic [4:0] PKT_LIMIT  = 5'(MAX_PKTS);

    sched_state_t r_state;
    logic         r_blank;
    logic [5:0]   r_cnt;
    logic [4:0]   r_pkts;
    logic [3:0]   r_grant;
    logic [1:0]   r_pkt_sel;
    logic         r_preamble;
    logic         r_guard;
    logic         r_data;
    logic         r_first;
    logic         r_abort;

    logic         w_rise;
    logic         w_island;
    logic         w_drop;
    logic         w_decide;
    logic         w_take;
    logic         w_arb_valid;
    logic [1:0]   w_arb_idx;

    assign w_rise   = i_blank & ~r_blank;
    assign w_island = (r_state == ST_PREAMBLE) || (r_state == ST_LGUARD) ||
                      (r_state == ST_PACKET)   || (r_state == ST_TGUARD);
    assign w_drop   = !i_blank && (w_island || (r_state == ST_DELAY));
    assign w_decide = ((r_state == ST_LGUARD) && (r_cnt == GUARD_LAST)) ||
                      ((r_state == ST_PACKET) && (r_cnt == PKT_LAST) && (r_pkts < PKT_LIMIT));
    assign w_take   = w_decide && w_arb_valid && !w_drop;

    hdmi_sched_arbiter u_arbiter (
        .i_pixclk (i_pixclk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req),
        .i_take   (w_take),
        .o_valid  (w_arb_valid),
        .o_idx    (w_arb_idx)
    );

    // Island sequencer with registered period flags and grant pulse
    always_ff @(posedge i_pixclk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_blank    <= 1'b0;
            r_cnt      <= 6'd0;
            r_pkts     <= 5'd0;
            r_grant    <= 4'b0000;
            r_pkt_sel  <= 2'd0;
            r_preamble <= 1'b0;
            r_guard    <= 1'b0;
            r_data     <= 1'b0;
            r_first    <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_blank <= i_blank;
            r_grant <= 4'b0000;
            r_abort <= 1'b0;
            if (w_drop) begin
                r_state    <= ST_IDLE;
                r_cnt      <= 6'd0;
                r_pkts     <= 5'd0;
                r_pkt_sel  <= 2'd0;
                r_preamble <= 1'b0;
                r_guard    <= 1'b0;
                r_data     <= 1'b0;
                r_first    <= 1'b0;
                r_abort    <= w_island;
            end else if (w_take) begin
                r_state   <= ST_PACKET;
                r_cnt     <= 6'd0;
                r_pkts    <= r_pkts + 5'd1;
                r_guard   <= 1'b0;
                r_data    <= 1'b1;
                r_first   <= (r_state == ST_LGUARD);
                r_pkt_sel <= w_arb_idx;
                r_grant   <= src_onehot(w_arb_idx);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_state <= i_enable ? ST_DELAY : ST_DONE;
                            r_cnt   <= 6'd1;
                            r_pkts  <= 5'd0;
                        end
                    end
                    ST_DELAY: begin
                        if (r_cnt == DLY_LAST) begin
                            r_cnt <= 6'd0;
                            if (|i_req) begin
                                r_state    <= ST_PREAMBLE;
                                r_preamble <= 1'b1;
                            end else begin
                                r_state <= ST_DONE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (r_cnt == PRE_LAST) begin
                            r_state    <= ST_LGUARD;
                            r_cnt      <= 6'd0;
                            r_preamble <= 1'b0;
                            r_guard    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    ST_LGUARD: begin
                        // Only reached at the last cycle when nothing is requesting
                        if (r_cnt == GUARD_LAST) begin
                            r_state <= ST_TGUARD;
                            r_cnt   <= 6'd0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    ST_PACKET: begin
                        if (r_cnt == PKT_LAST) begin
                            r_state   <= ST_TGUARD;
                            r_cnt     <= 6'd0;
                            r_data    <= 1'b0;
                            r_first   <= 1'b0;
                            r_pkt_sel <= 2'd0;
                            r_guard   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    ST_TGUARD: begin
                        if (r_cnt == GUARD_LAST) begin
                            r_state <= ST_DONE;
                            r_cnt   <= 6'd0;
                            r_guard <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    ST_DONE: begin
                        if (!i_blank) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= 6'd0;
                        r_pkts     <= 5'd0;
                        r_pkt_sel  <= 2'd0;
                        r_preamble <= 1'b0;
                        r_guard    <= 1'b0;
                        r_data     <= 1'b0;
                        r_first    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_grant    = r_grant;
    assign o_pkt_sel  = r_pkt_sel;
    assign o_preamble = r_preamble;
    assign o_guard    = r_guard;
    assign o_data     = r_data;
    assign o_first    = r_first;
    assign o_abort    = r_abort;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Scoreboard bench for hdmi_island_scheduler: per-line timelines built from the island rules.
// Honours HDMI_SCHED_INFOFRAME_RR_EN in the reference model.
module tb_hdmi_island_scheduler;

    localparam int START_DLY = 12;
    localparam int MAX_PKTS  = 2;
    localparam int NC        = 128;
    localparam int GAP       = 4;
    localparam int NEVER     = 100000;
`ifdef HDMI_SCHED_INFOFRAME_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_blank = 1'b0;
    logic [3:0] i_req = 4'b0000;
    logic [3:0] o_grant;
    logic [1:0] o_pkt_sel;
    logic       o_preamble, o_guard, o_data, o_first, o_abort;

    always #5 clk = ~clk;

    hdmi_island_scheduler #(.START_DLY(START_DLY), .MAX_PKTS(MAX_PKTS)) dut (
        .i_pixclk   (clk),
        .i_rst_n    (i_rst_n),
        .i_enable   (i_enable),
        .i_blank    (i_blank),
        .i_req      (i_req),
        .o_grant    (o_grant),
        .o_pkt_sel  (o_pkt_sel),
        .o_preamble (o_preamble),
        .o_guard    (o_guard),
        .o_data     (o_data),
        .o_first    (o_first),
        .o_abort    (o_abort)
    );

    // Record bits: 10 pre, 9 guard, 8 data, 7 first, 6 abort, 5:2 grant, 1:0 sel
    typedef struct {
        int          line;
        int          cyc;
        logic [10:0] v;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        mon_e;
    logic [10:0] mon_act;
    int          total = 0;
    int          bad = 0;
    int          line_no = 0;
    logic [10:0] exp_v[NC];
    int          m_set[4];
    int          m_drop[4];
    int          rr_model = 0;
    logic [3:0]  carry = 4'b0000;

    function automatic logic [3:0] req_at(input int k);
        logic [3:0] r;
        for (int s = 0; s < 4; s++) r[s] = (k >= m_set[s]) && (k < m_drop[s]);
        return r;
    endfunction

    function automatic int pick(input logic [3:0] r, input int rr);
        if (r[0]) return 0;
        if (r[1]) return 1;
        if (r[2] && r[3] && RR_ON && (rr != 0)) return 3;
        if (r[2]) return 2;
        return 3;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = {o_preamble, o_guard, o_data, o_first, o_abort, o_grant, o_pkt_sel};
            total++;
            if (mon_act !== mon_e.v) begin
                bad++;
                if (bad <= 40)
                    $display("FAIL outputs line=%0d cycle=%0d got(pre,grd,dat,first,abt,grant,sel)=%b required=%b",
                             mon_e.line, mon_e.cyc, mon_act, mon_e.v);
            end
        end
    end

    task automatic drive_cycle(input logic rst_v, input logic blank_v, input logic en_v,
                               input logic [3:0] req_v, input logic [10:0] ev, input int cyc);
        rec_t r;
        @(posedge clk);
        #2;
        i_rst_n  = rst_v;
        i_blank  = blank_v;
        i_enable = en_v;
        i_req    = req_v;
        r.line = line_no;
        r.cyc  = cyc;
        r.v    = ev;
        exp_q.push_back(r);
    endtask

    task automatic run_line(input bit ln_en, input logic [3:0] newreq, input int late_src,
                            input int late_cyc, input int hold, input bit do_rst);
        logic [3:0] init_r;
        logic [3:0] one;
        logic       abt;
        int         d, pk, w, len;
        line_no++;
        len    = hold + GAP;
        init_r = carry | newreq;
        for (int s = 0; s < 4; s++) begin
            m_set[s]  = init_r[s] ? 0 : NEVER;
            m_drop[s] = NEVER;
        end
        if (late_src >= 0 && !init_r[late_src]) m_set[late_src] = late_cyc;
        for (int k = 0; k < NC; k++) exp_v[k] = 11'd0;

        if (ln_en && (START_DLY - 1 < hold) && (req_at(START_DLY - 1) != 4'b0000)) begin
            for (int k = START_DLY; k < START_DLY + 8; k++) exp_v[k][10] = 1'b1;
            exp_v[START_DLY + 8][9] = 1'b1;
            exp_v[START_DLY + 9][9] = 1'b1;
            d  = START_DLY + 9;
            pk = 0;
            while (d < hold && pk < MAX_PKTS && req_at(d) != 4'b0000) begin
                w = pick(req_at(d), rr_model);
                pk++;
                one = 4'b0001;
                exp_v[d + 1][5:2] = one << w;
                for (int k = d + 1; k <= d + 32; k++) begin
                    exp_v[k][8]   = 1'b1;
                    exp_v[k][7]   = (pk == 1);
                    exp_v[k][1:0] = 2'(w);
                end
                m_drop[w] = d + 2;
                if (w >= 2) rr_model = rr_model ^ 1;
                d = d + 32;
            end
            exp_v[d + 1][9] = 1'b1;
            exp_v[d + 2][9] = 1'b1;
        end

        abt = !do_rst && (exp_v[hold][10] || exp_v[hold][9] || exp_v[hold][8]);
        for (int k = hold + 1; k < NC; k++) exp_v[k] = 11'd0;
        exp_v[hold + 1][6] = abt;
        if (do_rst) rr_model = 0;

        for (int k = 0; k < len; k++)
            drive_cycle((do_rst && (k == hold || k == hold + 1)) ? 1'b0 : 1'b1,
                        (k < hold), ln_en, req_at(k), exp_v[k], k);
        carry = req_at(len);
    endtask

    initial begin
        int h, ls, lc;
        bit en_r, dr;
        logic [3:0] nr;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 4'b0000, 11'd0, i);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 4'b0000, 11'd0, i);

        run_line(1'b1, 4'b0011, -1, 0, 100, 1'b0);  // ACR@22, AUD@54, trailing guard 86-87
        run_line(1'b1, 4'b0000, -1, 0, 30, 1'b0);   // nothing requested
        run_line(1'b1, 4'b1111, -1, 0, 100, 1'b0);  // two packets only
        run_line(1'b1, 4'b0000, -1, 0, 100, 1'b0);  // leftover infoframes next line
        run_line(1'b1, 4'b0011, -1, 0, 40, 1'b0);   // blank falls mid-packet
        run_line(1'b1, 4'b0001, -1, 0, 30, 1'b1);   // reset mid-island
        run_line(1'b1, 4'b0100, -1, 0, 100, 1'b0);  // clean island after reset
        run_line(1'b0, 4'b1000, -1, 0, 50, 1'b0);   // disabled line
        run_line(1'b1, 4'b0001, 1, 30, 100, 1'b0);  // late audio waits for next decision
        run_line(1'b1, 4'b1100, -1, 0, 100, 1'b0);
        run_line(1'b1, 4'b1100, -1, 0, 100, 1'b0);

        for (int i = 0; i < 30; i++) begin
            en_r = ($urandom_range(0, 7) != 0);
            nr   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            ls   = int'($urandom_range(0, 4)) - 1;
            lc   = int'($urandom_range(0, 90));
            h    = ($urandom_range(0, 1) == 0) ? 100 : int'($urandom_range(2, 99));
            dr   = ($urandom_range(0, 9) == 0);
            run_line(en_r, nr, ls, lc, h, dr);
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_island_scheduler.md
HDMI_ISLAND_SCHEDULER -- requirements
Module: hdmi_island_scheduler

Interface
REQ-001 SHALL have parameter START_DLY, default 12: control-period cycles counted from the detected blank rising edge before the preamble starts.
REQ-002 SHALL have parameter MAX_PKTS, default 2, legal range 1..18: maximum packets per data island.
REQ-003 SHALL have port i_pixclk, input, 1 bit: the only clock.
REQ-004 SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port i_enable, input, 1 bit: allows island generation; sampled only at the blank rising edge.
REQ-006 SHALL have port i_blank, input, 1 bit: video blanking.
REQ-007 SHALL have port i_req, input, 4 bits: packet requests, [0]=ACR, [1]=audio sample, [2]=AVI infoframe, [3]=audio infoframe.
REQ-008 SHALL have port o_grant, output, 4 bits: one-hot, one-cycle grant pulse.
REQ-009 SHALL have port o_pkt_sel, output, 2 bits: index of the source currently transmitting.
REQ-010 SHALL have port o_preamble, output, 1 bit: data-island preamble period.
REQ-011 SHALL have port o_guard, output, 1 bit: leading or trailing guard band.
REQ-012 SHALL have port o_data, output, 1 bit: packet period (TERC4).
REQ-013 SHALL have port o_first, output, 1 bit: high throughout the first packet of the island.
REQ-014 SHALL have port o_abort, output, 1 bit: one-cycle pulse when an island is truncated.

Function
REQ-015 SHALL use states IDLE, DELAY, PREAMBLE (8 cycles), LGUARD (2), PACKET (32), TGUARD (2) and DONE.
REQ-016 SHALL detect the blank rising edge as i_blank=1 while the previously registered i_blank=0; that cycle is cycle 0.
- If i_enable=1 at cycle 0, the state SHALL move IDLE->DELAY.
- Otherwise the state SHALL move to DONE.
REQ-017 SHALL leave DELAY after START_DLY cycles:
- To PREAMBLE if any i_req bit is set on the final DELAY cycle.
- Otherwise to DONE, with no island this line.
REQ-018 SHALL go PREAMBLE->LGUARD->PACKET; o_preamble, o_guard and o_data SHALL be high exactly in their respective states.
REQ-019 SHALL perform arbitration on the final LGUARD cycle and on the final (32nd) PACKET cycle.
- The winner is registered; o_grant[winner] pulses on the first cycle of the next packet.
- o_pkt_sel SHALL hold the winner for all 32 cycles.
REQ-020 SHALL use fixed priority ACR > audio sample > AVI > audio infoframe.
REQ-021 SHALL, on the 32nd PACKET cycle, start another PACKET with no gap if a request is pending and packets sent < MAX_PKTS; otherwise it SHALL go to TGUARD.
REQ-022 SHALL go TGUARD->DONE; DONE SHALL hold until i_blank=0, then go to IDLE.
REQ-023 SHALL treat requests as level-held until granted; a source drops its request the cycle after its grant. A request asserted after the arbitration cycle waits for the next decision point.
REQ-024 SHALL handle i_blank=0 in any state other than IDLE and DONE:
- Go to IDLE next cycle and clear all outputs.
- Pulse o_abort only if the state was PREAMBLE, LGUARD, PACKET or TGUARD.
- Issue no further grants.
REQ-025 SHALL, for a blank rising edge seen while not in IDLE (glitch), ignore it.
REQ-026 SHALL drive o_grant=0 on any cycle where no packet starts.
REQ-027 SHALL use a cycle counter of 6 bits and a packet counter of 5 bits, with no wrap within an island.

Reset
REQ-028 SHALL, when i_rst_n=0 at a clock edge, go to IDLE:
- All outputs 0, o_pkt_sel=0.
- Counters, edge-detect register and round-robin pointer cleared.
- This applies mid-island too, with no o_abort pulse.

Configuration
REQ-029 SHALL support macro HDMI_SCHED_INFOFRAME_RR_EN:
- When defined, sources 2 and 3 SHALL share the lowest priority level round-robin, with the pointer toggling after each grant to either.
- When undefined, strict fixed priority per REQ-020 SHALL apply.
- ACR and audio sample SHALL be unaffected in both cases.

Structure
REQ-030 SHALL place the state enum, source index constants (SRC_ACR=0, SRC_AUD=1, SRC_AVI=2, SRC_AIF=3) and PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32 in shared package hdmi_sched_pkg.
REQ-031 SHALL place arbitration, including the round-robin pointer, in sub-module hdmi_sched_arbiter.

Verification
REQ-032 SHALL cover: i_req=4'b0011 held, blank rises at cycle 0 -> preamble cycles 12-19, guard 20-21, grant 4'b0001 at cycle 22, grant 4'b0010 at cycle 54, trailing guard cycles 86-87.
REQ-033 SHALL cover: i_req=0 through cycle 11 -> no preamble, no grant, DONE until blank falls.
REQ-034 SHALL cover: MAX_PKTS=2, i_req=4'b1111 held -> exactly two grants (ACR, audio); AVI waits for the next line.
REQ-035 SHALL cover: blank falls at cycle 40 -> o_abort pulse at cycle 41, all outputs 0, no grant at cycle 54.
REQ-036 SHALL cover: with HDMI_SCHED_INFOFRAME_RR_EN, MAX_PKTS=1, i_req=4'b1100 held over two lines -> grants 4'b0100 then 4'b1000; without the macro -> 4'b0100 on both lines.
REQ-037 SHALL cover: i_rst_n=0 at cycle 30 -> outputs 0 next cycle; re-release gives a clean island on the next blank edge.
